// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - 32-bit signed radix-2 Booth multiplier and restoring divider
// Divider datapath, DIV and FIX states are included only when MD_DIV_EN is defined.
module mult_div_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div0
);

`ifdef MD_DIV_EN
   typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;
`endif

   state_t      state, state_next;
   logic [4:0]  cnt;
   logic [32:0] acc;
   logic [31:0] qr;
   logic        qm1;
   logic [31:0] m;
   logic        div_err;

   // Booth step: 33-bit accumulator absorbs the overflow of +/- 0x80000000.
   logic [32:0] booth_sum;
   logic [32:0] booth_acc;
   logic [31:0] booth_q;
   logic        booth_qm1;

   always_comb begin
      booth_sum = acc;
      case ({qr[0], qm1})
         2'b01:   booth_sum = acc + {m[31], m};
         2'b10:   booth_sum = acc - {m[31], m};
         default: booth_sum = acc;
      endcase
      {booth_acc, booth_q, booth_qm1} = {booth_sum[32], booth_sum, qr};
   end

`ifdef MD_DIV_EN
   logic        neg_q, neg_r;
   logic [31:0] a_mag, b_mag;
   logic [32:0] rem_sh;
   logic [33:0] diff;
   logic        div_ge;
   logic [32:0] div_acc;
   logic [31:0] div_q;
   logic [31:0] quo_fix, rem_fix;

   always_comb begin
      a_mag   = a[31] ? (32'd0 - a) : a;
      b_mag   = b[31] ? (32'd0 - b) : b;
      rem_sh  = {acc[31:0], qr[31]};
      diff    = {1'b0, rem_sh} - {2'b00, m};
      div_ge  = ~diff[33];
      div_acc = div_ge ? diff[32:0] : rem_sh;
      div_q   = {qr[30:0], div_ge};
      quo_fix = neg_q ? (32'd0 - qr) : qr;
      rem_fix = neg_r ? (32'd0 - acc[31:0]) : acc[31:0];
   end
`endif

   always_comb begin
      state_next = state;
      div_err    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
`ifdef MD_DIV_EN
               if (!op) begin
                  state_next = S_MULT;
               end else if (b == 32'd0) begin
                  state_next = S_DONE;
                  div_err    = 1'b1;
               end else begin
                  state_next = S_DIV;
               end
`else
               state_next = op ? S_DONE : S_MULT;
               div_err    = op;
`endif
            end
         end
         S_MULT:  if (cnt == 5'd31) state_next = S_DONE;
`ifdef MD_DIV_EN
         S_DIV:   if (cnt == 5'd31) state_next = S_FIX;
         S_FIX:   state_next = S_DONE;
`endif
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt  <= 5'd0;
         acc  <= 33'd0;
         qr   <= 32'd0;
         qm1  <= 1'b0;
         m    <= 32'd0;
         hi   <= 32'd0;
         lo   <= 32'd0;
         done <= 1'b0;
         div0 <= 1'b0;
`ifdef MD_DIV_EN
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`endif
      end else begin
         done <= (state_next == S_DONE);
         div0 <= div_err;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt <= 5'd0;
                  acc <= 33'd0;
                  qm1 <= 1'b0;
                  qr  <= b;
                  m   <= a;
`ifdef MD_DIV_EN
                  if (op) begin
                     qr <= a_mag;
                     m  <= b_mag;
                  end
                  neg_q <= a[31] ^ b[31];
                  neg_r <= a[31];
`endif
               end
            end
            S_MULT: begin
               acc <= booth_acc;
               qr  <= booth_q;
               qm1 <= booth_qm1;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  hi <= booth_acc[31:0];
                  lo <= booth_q;
               end
            end
`ifdef MD_DIV_EN
            S_DIV: begin
               acc <= div_acc;
               qr  <= div_q;
               cnt <= cnt + 5'd1;
            end
            S_FIX: begin
               hi <= rem_fix;
               lo <= quo_fix;
            end
`endif
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven bench for mult_div_unit
// Expectations follow the build: divider vectors expect div0 unless MD_DIV_EN is defined.
module tb_mult_div_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [31:0] hi, lo;
   logic        busy, done, div0;

   mult_div_unit dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
   );

   always #5 clock = ~clock;

`ifdef MD_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        div0;
      int          lat;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Accept one op, scramble inputs afterwards, wait (bounded) for done, then step into IDLE.
   task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rd0, output logic flags_ok);
      @(negedge clock);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clock); #1;
      start = 1'b0; op = ~o; a = ~x; b = ~y;
      lat = 1;
      flags_ok = 1'b1;
      while (!done && lat < 60) begin
         if (!busy || div0) flags_ok = 1'b0;
         @(posedge clock); #1;
         lat++;
      end
      rh = hi; rl = lo; rd0 = div0;
      if (!busy) flags_ok = 1'b0;
      @(posedge clock); #1;
      if (done || div0 || busy) flags_ok = 1'b0;
   endtask

   initial begin
      int          lat, ndone, first;
      logic [31:0] rh, rl, eh, el;
      logic        rd0, ok, ed0, bad;
      int          elat;

      vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
      vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
      vecs[2]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
      vecs[3]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
      vecs[4]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
      vecs[5]  = '{1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
      vecs[6]  = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 33};
      vecs[7]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
      vecs[8]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
      vecs[9]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
      vecs[10] = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 34};
      vecs[11] = '{1'b1, 32'h00000005, 32'h00000007, 32'h00000005, 32'h00000000, 1'b0, 34};
      vecs[12] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 34};
      vecs[13] = '{1'b1, 32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000, 1'b0, 34};
      vecs[14] = '{1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34};
      vecs[15] = '{1'b1, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003, 1'b0, 34};
      vecs[16] = '{1'b0, 32'h00000066, 32'h2AAAAAAB, 32'h00000011, 32'h00000022, 1'b0, 33};
      vecs[17] = '{1'b1, 32'h00005555, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1};
      vecs[18] = '{1'b0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33};

      #12;
      check("reset_hi", {32'd0, hi}, 64'd0);
      check("reset_lo", {32'd0, lo}, 64'd0);
      check("reset_flags", {61'd0, busy, done, div0}, 64'd0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         eh = vecs[i].hi; el = vecs[i].lo; ed0 = vecs[i].div0; elat = vecs[i].lat;
         if (vecs[i].op && !DIV_EN) begin
            ed0 = 1'b1; elat = 1;
         end
         if (ed0) begin
            eh = m_hi; el = m_lo;
         end
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rh, rl, rd0, ok);
         check($sformatf("v%0d_latency", i), lat, elat);
         check($sformatf("v%0d_hi", i), {32'd0, rh}, {32'd0, eh});
         check($sformatf("v%0d_lo", i), {32'd0, rl}, {32'd0, el});
         check($sformatf("v%0d_div0", i), {63'd0, rd0}, {63'd0, ed0});
         check($sformatf("v%0d_busy_done_seq", i), {63'd0, ok}, 64'd1);
         if (!ed0) begin
            m_hi = eh; m_lo = el;
         end
      end

      // Stray start (with div-by-zero operands) in the middle of a mult must be ignored.
      @(negedge clock);
      start = 1'b1; op = 1'b0; a = 32'h00000007; b = 32'hFFFFFFFD;
      @(posedge clock); #1;
      ndone = 0; first = 0; bad = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            ndone++;
            if (first == 0) begin
               first = c; rh = hi; rl = lo;
            end
         end
         if (div0) bad = 1'b1;
         start = (c == 5); op = 1'b1; b = 32'd0;
         @(posedge clock); #1;
      end
      start = 1'b0;
      check("stray_start_done_count", ndone, 1);
      check("stray_start_done_cycle", first, 33);
      check("stray_start_hi", {32'd0, rh}, 64'hFFFFFFFF);
      check("stray_start_lo", {32'd0, rl}, 64'hFFFFFFEB);
      check("stray_start_no_div0", {63'd0, bad}, 64'd0);
      check("stray_start_idle", {63'd0, busy}, 64'd0);

      // Asynchronous reset in the middle of an operation.
      @(negedge clock);
      start = 1'b1; op = 1'b0; a = 32'h00000066; b = 32'h2AAAAAAB;
      @(posedge clock); #1;
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(posedge clock); #1;
      end
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_hi", {32'd0, hi}, 64'd0);
      check("async_reset_lo", {32'd0, lo}, 64'd0);
      check("async_reset_flags", {61'd0, busy, done, div0}, 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      ndone = 0; bad = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clock); #1;
         if (done || div0) ndone++;
         if (busy) bad = 1'b1;
      end
      check("post_reset_no_done", ndone, 0);
      check("post_reset_idle", {63'd0, bad}, 64'd0);
      check("post_reset_hi_held", {32'd0, hi}, 64'd0);

      run_op(1'b0, 32'h00000007, 32'hFFFFFFFD, lat, rh, rl, rd0, ok);
      check("after_reset_latency", lat, 33);
      check("after_reset_hi", {32'd0, rh}, 64'hFFFFFFFF);
      check("after_reset_lo", {32'd0, rl}, 64'hFFFFFFEB);
      check("after_reset_div0", {63'd0, rd0}, 64'd0);
      check("after_reset_busy_done_seq", {63'd0, ok}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
